crc_job_scheduler: RTL

Shares one `crcencoder` engine (bit-serial, `DATAWIDTH` cycles per word) among `NUM_REQ` requesters. It arbitrates round-robin and launches the engine with a one-cycle `ctrlen`. It then waits out the engine's busy window, captures the CRC and returns it to the winning requester with a done pulse. It sits between the requester ports and the single engine instance.

---
 rtl/crc_sched_pkg.sv | 36 +++
 rtl/crc_rr_arbiter.sv | 41 ++++
 rtl/crc_job_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/crc_sched_pkg.sv
// Shared types and helpers for the CRC job scheduler: FSM state encoding,
// watchdog offset and the round-robin pick function.
package crc_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    DELIVER
  } crc_sched_state_t;

  // Watchdog limit is DATAWIDTH plus this many cycles in WAIT_DONE.
  localparam int CRC_SCHED_TIMEOUT = 8;

  localparam int RR_MAX = 8;

  // First set bit at or after pointer, wrapping modulo 8; unused upper bits must be zero.
  function automatic logic [2:0] rr_pick(input logic [RR_MAX-1:0] mask,
                                         input logic [2:0]        pointer);
    logic [2:0] idx;
    logic [2:0] cand;
    logic       found;
    idx   = pointer;
    found = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      cand = pointer + 3'(i);
      if (!found && mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/crc_rr_arbiter.sv
// Round-robin requester selection: combinational pick (index and one-hot)
// from the current pointer, plus the pointer register advanced on launch.
module crc_rr_arbiter
  import crc_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [IW-1:0]      last_idx,
  output logic               any,
  output logic [IW-1:0]      idx,
  output logic [NUM_REQ-1:0] onehot
);

  logic [IW-1:0]     ptr_q;
  logic [RR_MAX-1:0] mask;
  logic [2:0]        pick;

  assign any = |req;

  always_comb begin
    mask   = RR_MAX'(req);
    pick   = rr_pick(mask, 3'(ptr_q));
    idx    = IW'(pick);
    onehot = any ? (NUM_REQ'(1) << idx) : '0;
  end

  // Pointer moves just past the requester that was launched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (last_idx == IW'(NUM_REQ - 1)) ? '0 : last_idx + IW'(1);
    end
  end

endmodule

// File: rtl/crc_job_scheduler.sv
// Shares one bit-serial CRC engine among NUM_REQ requesters, one job in flight.
// Optional watchdog on the engine busy window: define CRC_SCHED_TIMEOUT_EN.
module crc_job_scheduler
  import crc_sched_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATAWIDTH = 32,
  parameter  int CRCWIDTH  = 16,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*DATAWIDTH-1:0]      reqdata,
  input  logic [NUM_REQ*(CRCWIDTH+1)-1:0]   reqpoly,
  output logic [NUM_REQ-1:0]                grant,
  output logic                              done,
  output logic [IW-1:0]                     doneid,
  output logic [CRCWIDTH-1:0]               crcout,
  output logic                              err,
  output logic                              eng_resetn,
  output logic                              eng_ctrlen,
  output logic [DATAWIDTH-1:0]              eng_datain,
  output logic [CRCWIDTH:0]                 eng_genpoly,
  input  logic [CRCWIDTH-1:0]               eng_crcseq,
  input  logic                              eng_crcready
);

  crc_sched_state_t     state_q, state_d;
  logic [IW-1:0]        idx_q, doneid_q, arb_idx;
  logic [NUM_REQ-1:0]   sel_q, arb_onehot;
  logic [DATAWIDTH-1:0] data_q;
  logic [CRCWIDTH:0]    poly_q;
  logic [CRCWIDTH-1:0]  crc_q;
  logic                 rstn_q, arb_any, start_ok;
  logic                 load, capture, finish;

  crc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .advance  (state_q == LAUNCH),
    .last_idx (idx_q),
    .any      (arb_any),
    .idx      (arb_idx),
    .onehot   (arb_onehot)
  );

`ifdef CRC_SCHED_TIMEOUT_EN
  localparam int TO_LIMIT = DATAWIDTH + CRC_SCHED_TIMEOUT;
  localparam int TO_W     = $clog2(TO_LIMIT);

  logic [TO_W-1:0] wd_q;
  logic            err_q, hold_q, expire, kick;

  // Engine reset pulse covers DELIVER and the following cycle after a timeout.
  assign kick       = (state_q == DELIVER) && err_q;
  assign eng_resetn = rstn_q && !kick && !hold_q;
  assign err        = err_q;
  assign start_ok   = !hold_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q   <= '0;
      err_q  <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      wd_q   <= (state_q == WAIT_DONE) ? wd_q + TO_W'(1) : '0;
      hold_q <= kick;
      if (capture)     err_q <= 1'b0;
      else if (expire) err_q <= 1'b1;
    end
  end
`else
  assign eng_resetn = rstn_q;
  assign err        = 1'b0;
  assign start_ok   = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    grant      = '0;
    eng_ctrlen = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
`ifdef CRC_SCHED_TIMEOUT_EN
    expire     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (arb_any && start_ok) begin
          load    = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        grant      = sel_q;
        eng_ctrlen = 1'b1;
        state_d    = WAIT_BUSY;
      end
      // Engine ready is still high here from before the launch; skip it.
      WAIT_BUSY: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (eng_crcready) begin
          capture = 1'b1;
          finish  = 1'b1;
          state_d = DELIVER;
        end
`ifdef CRC_SCHED_TIMEOUT_EN
        else if (wd_q == TO_W'(TO_LIMIT - 1)) begin
          expire  = 1'b1;
          finish  = 1'b1;
          state_d = DELIVER;
        end
`endif
      end
      DELIVER: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstn_q   <= 1'b0;
      idx_q    <= '0;
      sel_q    <= '0;
      data_q   <= '0;
      poly_q   <= '0;
      crc_q    <= '0;
      doneid_q <= '0;
    end else begin
      rstn_q <= 1'b1;
      if (load) begin
        idx_q  <= arb_idx;
        sel_q  <= arb_onehot;
        data_q <= reqdata[int'(arb_idx)*DATAWIDTH +: DATAWIDTH];
        poly_q <= reqpoly[int'(arb_idx)*(CRCWIDTH+1) +: CRCWIDTH+1];
      end
      // Result fields hold until the next job finishes.
      if (finish) begin
        crc_q    <= capture ? eng_crcseq : '0;
        doneid_q <= idx_q;
      end
    end
  end

  assign doneid      = doneid_q;
  assign crcout      = crc_q;
  assign eng_datain  = data_q;
  assign eng_genpoly = poly_q;

endmodule
